vc_skid_reg: RTL

// Two-entry val/rdy skid register decoupling a producer (enq) from a consumer
// (deq). Behaves as a pipeline register that sustains one message per cycle,

---
 rtl/vc_skid_reg.sv | 83 ++++++++
 1 files changed

// File: rtl/vc_skid_reg.sv
// Two-entry val/rdy skid register. enq_rdy depends only on state (and reset),
// so the consumer's deq_rdy never combinationally reaches the producer.
//
// state | meaning
// EMPTY | no valid entries; deq_val low
// ONE   | main holds the head message
// TWO   | main holds the head, skid holds the second; enq blocked
module vc_skid_reg #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg,
    output logic [1:0]         num_entries
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]         state;
    logic [p_nbits-1:0] main_msg;
    logic [p_nbits-1:0] skid_msg;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_rdy     = reset & (state != TWO);
    assign deq_val     = (state != EMPTY);
    assign deq_msg     = main_msg;
    assign num_entries = state;
    assign enq_fire    = enq_val & enq_rdy;
    assign deq_fire    = deq_val & deq_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            main_msg <= '0;
            skid_msg <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (enq_fire) begin
                        state    <= ONE;
                        main_msg <= enq_msg;
                    end
                end
                ONE: begin
                    if (enq_fire && deq_fire) begin
                        main_msg <= enq_msg;
                    end else if (enq_fire) begin
                        state    <= TWO;
                        skid_msg <= enq_msg;
                    end else if (deq_fire) begin
                        state    <= EMPTY;
                    end
                end
                TWO: begin
                    // Second entry moves up to the head when the consumer takes one.
                    if (deq_fire) begin
                        state    <= ONE;
                        main_msg <= skid_msg;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown({enq_val, deq_rdy}))
                else $error("enq_val/deq_rdy unknown out of reset");
        end
    end
`endif

endmodule
